// File: rtl/nv_nvdla_rt_csb_pkg.sv
// CSB retiming pipe: shared widths, CSB request field offsets and
// response packet ids.
package nv_nvdla_rt_csb_pkg;

  localparam int CSB_REQ_W   = 63;
  localparam int CSB_RESP_W  = 34;
  localparam int CSB_STAGES  = 3;
  localparam int CSB_OUTS_W  = 4;

  localparam int REQ_ADDR_LSB    = 0;
  localparam int REQ_ADDR_MSB    = 21;
  localparam int REQ_WRITE_BIT   = 54;
  localparam int REQ_NPOSTED_BIT = 55;

  localparam int RESP_ID_LSB = 32;
  localparam int RESP_ID_W   = 2;

  typedef enum logic [RESP_ID_W-1:0] {
    CSB_RSP_READ  = 2'b00,
    CSB_RSP_WRITE = 2'b10
  } csb_rsp_id_e;

endpackage

// File: rtl/nv_nvdla_rt_csb_pipe_if.sv
// Handshake bundles for the CSB pipe: elastic request channel and
// valid-only response channel.
interface nv_nvdla_rt_csb_req_if
  import nv_nvdla_rt_csb_pkg::*;
#(
  parameter int W = CSB_REQ_W
);
  logic         pvld;
  logic         prdy;
  logic [W-1:0] pd;

  modport master (output pvld, output pd, input prdy);
  modport slave  (input pvld, input pd, output prdy);
endinterface

interface nv_nvdla_rt_csb_resp_if
  import nv_nvdla_rt_csb_pkg::*;
#(
  parameter int W = CSB_RESP_W
);
  logic         valid;
  logic [W-1:0] pd;

  modport master (output valid, output pd);
  modport slave  (input valid, input pd);
endinterface

// File: rtl/nv_nvdla_rt_skid_stage.sv
// One elastic request stage: main + skid register, ready is a flop
// so no combinational ready path crosses the stage.
module nv_nvdla_rt_skid_stage #(
  parameter int WIDTH = 32
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rstn,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_pd,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_pd,
  output logic             busy
);

  logic             main_vld;
  logic             skid_vld;
  logic [WIDTH-1:0] main_pd;
  logic [WIDTH-1:0] skid_pd;
  logic             in_acc;
  logic             main_ld;

  assign in_acc  = in_vld && in_rdy;
  assign main_ld = !main_vld || out_rdy;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      in_rdy   <= 1'b1;
    end else if (main_ld) begin
      main_vld <= skid_vld || in_acc;
      skid_vld <= 1'b0;
      in_rdy   <= 1'b1;
    end else if (in_acc) begin
      skid_vld <= 1'b1;
      in_rdy   <= 1'b0;
    end
  end

  // payload is qualified by the valids, so it carries no reset
  always_ff @(posedge nvdla_core_clk) begin
    if (main_ld)
      main_pd <= skid_vld ? skid_pd : in_pd;
    if (!main_ld && in_acc)
      skid_pd <= in_pd;
  end

  assign out_vld = main_vld;
  assign out_pd  = main_pd;
  assign busy    = main_vld || skid_vld;

endmodule

// File: rtl/nv_nvdla_rt_csb_pipe.sv
// CSB retiming pipe: elastic request stages, fixed-delay response
// stages, non-posted outstanding tracking with idle/error status.
module nv_nvdla_rt_csb_pipe
  import nv_nvdla_rt_csb_pkg::*;
#(
  parameter int REQ_W       = CSB_REQ_W,
  parameter int RESP_W      = CSB_RESP_W,
  parameter int REQ_STAGES  = CSB_STAGES,
  parameter int RESP_STAGES = CSB_STAGES,
  parameter int NPOSTED_BIT = REQ_NPOSTED_BIT,
  parameter int OUTS_W      = CSB_OUTS_W
) (
  input  logic                   nvdla_core_clk,
  input  logic                   nvdla_core_rstn,
  nv_nvdla_rt_csb_req_if.slave   req_src,
  nv_nvdla_rt_csb_req_if.master  req_dst,
  nv_nvdla_rt_csb_resp_if.slave  resp_src,
  nv_nvdla_rt_csb_resp_if.master resp_dst,
  output logic [OUTS_W-1:0]      outs_cnt,
  output logic                   idle,
  output logic                   outs_err
);

  logic              d_vld;
  logic              d_rdy;
  logic [REQ_W-1:0]  d_pd;
  logic              r_vld;
  logic [RESP_W-1:0] r_pd;
  logic              req_busy;
  logic              resp_busy;
  logic              inc;
  logic              dec;

  assign d_rdy          = req_dst.prdy;
  assign req_dst.pvld   = d_vld;
  assign req_dst.pd     = d_pd;
  assign resp_dst.valid = r_vld;
  assign resp_dst.pd    = r_pd;

  generate
    if (REQ_STAGES == 0) begin : g_req_wire
      assign d_vld        = req_src.pvld;
      assign d_pd         = req_src.pd;
      assign req_src.prdy = d_rdy;
      assign req_busy     = 1'b0;
    end else begin : g_req
      logic [REQ_STAGES:0]   vld;
      logic [REQ_STAGES:0]   rdy;
      logic [REQ_W-1:0]      pd [REQ_STAGES+1];
      logic [REQ_STAGES-1:0] busy;

      assign vld[0]          = req_src.pvld;
      assign pd[0]           = req_src.pd;
      assign req_src.prdy    = rdy[0];
      assign rdy[REQ_STAGES] = d_rdy;
      assign d_vld           = vld[REQ_STAGES];
      assign d_pd            = pd[REQ_STAGES];
      assign req_busy        = |busy;

      for (genvar i = 0; i < REQ_STAGES; i++) begin : g_stg
        nv_nvdla_rt_skid_stage #(.WIDTH(REQ_W)) u_stg (
          .nvdla_core_clk  (nvdla_core_clk),
          .nvdla_core_rstn (nvdla_core_rstn),
          .in_vld          (vld[i]),
          .in_rdy          (rdy[i]),
          .in_pd           (pd[i]),
          .out_vld         (vld[i+1]),
          .out_rdy         (rdy[i+1]),
          .out_pd          (pd[i+1]),
          .busy            (busy[i])
        );
      end
    end

    if (RESP_STAGES == 0) begin : g_resp_wire
      assign r_vld     = resp_src.valid;
      assign r_pd      = resp_src.pd;
      assign resp_busy = 1'b0;
    end else begin : g_resp
      logic [RESP_STAGES-1:0] vld;
      logic [RESP_W-1:0]      pd [RESP_STAGES];

      always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
          vld <= '0;
        end else begin
          vld[0] <= resp_src.valid;
          for (int i = 1; i < RESP_STAGES; i++)
            vld[i] <= vld[i-1];
        end
      end

      // payload holds across valid gaps
      always_ff @(posedge nvdla_core_clk) begin
        if (resp_src.valid)
          pd[0] <= resp_src.pd;
        for (int i = 1; i < RESP_STAGES; i++)
          if (vld[i-1])
            pd[i] <= pd[i-1];
      end

      assign r_vld     = vld[RESP_STAGES-1];
      assign r_pd      = pd[RESP_STAGES-1];
      assign resp_busy = |vld;
    end
  endgenerate

  assign inc = d_vld && d_rdy && d_pd[NPOSTED_BIT];
  assign dec = r_vld;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      outs_cnt <= '0;
      outs_err <= 1'b0;
      idle     <= 1'b1;
    end else begin
      unique case ({inc, dec})
        2'b10: begin
          if (&outs_cnt) outs_err <= 1'b1;
          else           outs_cnt <= outs_cnt + OUTS_W'(1);
        end
        2'b01: begin
          if (outs_cnt == '0) outs_err <= 1'b1;
          else                outs_cnt <= outs_cnt - OUTS_W'(1);
        end
        default: ;
      endcase
      idle <= !req_busy && !resp_busy && (outs_cnt == '0);
    end
  end

endmodule

// File: tb/tb_nv_nvdla_rt_csb_pipe.sv
// Bench for the CSB retiming pipe: default build, a 2-bit counter
// build for saturation, and a zero-stage wire build.
module tb_nv_nvdla_rt_csb_pipe;

  localparam logic [62:0] NP = 63'(1) << 55;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nv_nvdla_rt_csb_req_if  #(.W(63)) a_rqs(), a_rqd(), s_rqs(), s_rqd();
  nv_nvdla_rt_csb_req_if  #(.W(63)) w_rqs(), w_rqd();
  nv_nvdla_rt_csb_resp_if #(.W(34)) a_rss(), a_rsd(), s_rss(), s_rsd();
  nv_nvdla_rt_csb_resp_if #(.W(34)) w_rss(), w_rsd();

  logic [3:0] a_cnt, w_cnt;
  logic [1:0] s_cnt;
  logic a_idle, a_err, s_idle, s_err, w_idle, w_err;

  nv_nvdla_rt_csb_pipe dut (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
    .req_src(a_rqs), .req_dst(a_rqd),
    .resp_src(a_rss), .resp_dst(a_rsd),
    .outs_cnt(a_cnt), .idle(a_idle), .outs_err(a_err)
  );

  nv_nvdla_rt_csb_pipe #(.OUTS_W(2)) dut_s (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
    .req_src(s_rqs), .req_dst(s_rqd),
    .resp_src(s_rss), .resp_dst(s_rsd),
    .outs_cnt(s_cnt), .idle(s_idle), .outs_err(s_err)
  );

  nv_nvdla_rt_csb_pipe #(.REQ_STAGES(0), .RESP_STAGES(0)) dut_w (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
    .req_src(w_rqs), .req_dst(w_rqd),
    .resp_src(w_rss), .resp_dst(w_rsd),
    .outs_cnt(w_cnt), .idle(w_idle), .outs_err(w_err)
  );

  task automatic quiet_inputs();
    a_rqs.pvld = 0; a_rqs.pd = '0; a_rqd.prdy = 1;
    a_rss.valid = 0; a_rss.pd = '0;
    s_rqs.pvld = 0; s_rqs.pd = '0; s_rqd.prdy = 1;
    s_rss.valid = 0; s_rss.pd = '0;
    w_rqs.pvld = 0; w_rqs.pd = '0; w_rqd.prdy = 1;
    w_rss.valid = 0; w_rss.pd = '0;
  endtask

  task automatic do_reset();
    quiet_inputs();
    rstn = 0;
    repeat (2) @(negedge clk);
    rstn = 1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (a_rqs.prdy !== 1'b1) begin
      errors++; $display("FAIL rst_prdy got %b exp 1", a_rqs.prdy);
    end
    checks++;
    if (a_rqd.pvld !== 1'b0 || a_rsd.valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_valids got %b%b exp 00", a_rqd.pvld, a_rsd.valid);
    end
    checks++;
    if (a_cnt !== 4'd0 || a_err !== 1'b0 || a_idle !== 1'b1) begin
      errors++;
      $display("FAIL rst_status got %0d/%b/%b exp 0/0/1",
               a_cnt, a_err, a_idle);
    end
  endtask

  task automatic test_stream(input bit toggle);
    logic [62:0] q[$];
    int sent = 0;
    int got = 0;
    do_reset();
    for (int c = 0; c < 80 && got < 8; c++) begin
      if (toggle && !a_rqs.prdy) begin
        checks++;
        if (q.size() < 4) begin
          errors++;
          $display("FAIL early_backpressure got %0d held exp >=4", q.size());
        end
      end
      if (!toggle && sent < 8) begin
        checks++;
        if (a_rqs.prdy !== 1'b1) begin
          errors++; $display("FAIL full_rate_prdy got %b exp 1", a_rqs.prdy);
        end
      end
      a_rqd.prdy = toggle ? (c % 4 == 0 || c % 4 == 3) : 1'b1;
      if (a_rqd.pvld && a_rqd.prdy) begin
        checks++;
        if (q.size() == 0 || a_rqd.pd !== q[0]) begin
          errors++;
          $display("FAIL stream_order got %0h exp %0h", a_rqd.pd,
                   q.size() ? q[0] : 63'h7fff_ffff_ffff_ffff);
        end
        if (q.size() != 0) void'(q.pop_front());
        if (!toggle) begin
          checks++;
          if (c != got + 3) begin
            errors++; $display("FAIL stream_cycle got %0d exp %0d", c, got + 3);
          end
        end
        got++;
      end
      checks++;
      if (a_cnt !== 4'd0) begin
        errors++; $display("FAIL posted_cnt got %0d exp 0", a_cnt);
      end
      if (sent < 8) begin
        a_rqs.pvld = 1;
        a_rqs.pd = 63'(sent);
        if (a_rqs.prdy) begin
          q.push_back(63'(sent));
          sent++;
        end
      end else begin
        a_rqs.pvld = 0;
      end
      @(negedge clk);
    end
    checks++;
    if (got != 8) begin
      errors++; $display("FAIL stream_count got %0d exp 8", got);
    end
  endtask

  task automatic test_nposted();
    int exp_cnt[14] = '{0, 0, 0, 0, 1, 2, 3, 3, 3, 2, 1, 0, 0, 0};
    logic [33:0] rq[$];
    int rc[$];
    do_reset();
    for (int c = 0; c < 14; c++) begin
      checks++;
      if (a_cnt !== 4'(exp_cnt[c])) begin
        errors++;
        $display("FAIL np_cnt c%0d got %0d exp %0d", c, a_cnt, exp_cnt[c]);
      end
      if (c == 11 || c == 12) begin
        checks++;
        if (a_idle !== (c == 12)) begin
          errors++;
          $display("FAIL np_idle c%0d got %b exp %b", c, a_idle, c == 12);
        end
      end
      if (a_rsd.valid) begin
        checks++;
        if (rq.size() == 0 || a_rsd.pd !== rq[0] || c != rc[0]) begin
          errors++;
          $display("FAIL np_resp c%0d got %0h exp %0h",
                   c, a_rsd.pd, rq.size() ? rq[0] : 34'h3_ffff_ffff);
        end
        if (rq.size() != 0) begin
          void'(rq.pop_front());
          void'(rc.pop_front());
        end
      end
      a_rqs.pvld = (c < 3);
      a_rqs.pd = NP | 63'(c);
      a_rss.valid = (c >= 5 && c <= 7);
      a_rss.pd = 34'h2_0000_0000 | 34'(c);
      if (a_rss.valid) begin
        rq.push_back(a_rss.pd);
        rc.push_back(c + 3);
      end
      @(negedge clk);
    end
    quiet_inputs();
    checks++;
    if (rq.size() != 0) begin
      errors++; $display("FAIL np_resp_missing got %0d left exp 0", rq.size());
    end
  endtask

  task automatic test_resp_hold();
    logic [33:0] rq[$];
    logic [33:0] held = 34'h2_0000_0001;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      checks++;
      if (a_rsd.valid !== (c == 3)) begin
        errors++;
        $display("FAIL pulse_valid c%0d got %b exp %b", c, a_rsd.valid, c == 3);
      end
      if (a_rsd.valid && rq.size() != 0) void'(rq.pop_front());
      if (c >= 3) begin
        checks++;
        if (a_rsd.pd !== held) begin
          errors++;
          $display("FAIL pulse_hold c%0d got %0h exp %0h", c, a_rsd.pd, held);
        end
      end
      a_rss.valid = (c == 0);
      a_rss.pd = (c == 0) ? held : 34'h1_2345_6789;
      if (a_rss.valid) rq.push_back(a_rss.pd);
      @(negedge clk);
    end
    quiet_inputs();
    checks++;
    if (rq.size() != 0) begin
      errors++; $display("FAIL pulse_missing got %0d left exp 0", rq.size());
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      if (c >= 6) begin
        checks++;
        if (s_cnt !== 2'd3 || s_err !== (c >= 7)) begin
          errors++;
          $display("FAIL sat c%0d got %0d/%b exp 3/%b", c, s_cnt, s_err, c >= 7);
        end
      end
      s_rqs.pvld = (c < 4);
      s_rqs.pd = NP | 63'(c);
      @(negedge clk);
    end
    do_reset();
    for (int c = 0; c < 7; c++) begin
      if (c >= 3) begin
        checks++;
        if (s_cnt !== 2'd0 || s_err !== (c >= 4)) begin
          errors++;
          $display("FAIL under c%0d got %0d/%b exp 0/%b", c, s_cnt, s_err, c >= 4);
        end
      end
      s_rss.valid = (c == 0);
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    a_rqd.prdy = 0;
    for (int c = 0; c < 5; c++) begin
      a_rqs.pvld = (c < 2);
      a_rqs.pd = 63'(c + 9);
      a_rss.valid = (c == 0);
      @(negedge clk);
    end
    checks++;
    if (a_rqd.pvld !== 1'b1 || a_err !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre got %b/%b exp 1/1", a_rqd.pvld, a_err);
    end
    rstn = 0;
    #1;
    checks++;
    if (a_rqd.pvld !== 0 || a_rsd.valid !== 0 || a_cnt !== 0 || a_err !== 0) begin
      errors++;
      $display("FAIL mid_clear got %b%b/%0d/%b exp 00/0/0",
               a_rqd.pvld, a_rsd.valid, a_cnt, a_err);
    end
    quiet_inputs();
    @(negedge clk);
    rstn = 1;
    @(negedge clk);
    checks++;
    if (a_rqs.prdy !== 1'b1 || a_idle !== 1'b1) begin
      errors++;
      $display("FAIL mid_release got %b/%b exp 1/1", a_rqs.prdy, a_idle);
    end
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (a_rqd.pvld !== 1'b0) begin
        errors++; $display("FAIL mid_ghost c%0d got 1 exp 0", c);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_wire();
    do_reset();
    w_rqs.pvld = 1;
    w_rqs.pd = NP | 63'(5);
    w_rqd.prdy = 0;
    #1;
    checks++;
    if (w_rqd.pvld !== 1'b1 || w_rqd.pd !== (NP | 63'(5)) || w_rqs.prdy !== 1'b0) begin
      errors++;
      $display("FAIL wire_req got %b/%0h/%b exp 1/%0h/0",
               w_rqd.pvld, w_rqd.pd, w_rqs.prdy, NP | 63'(5));
    end
    w_rqd.prdy = 1;
    @(negedge clk);
    w_rqs.pvld = 0;
    checks++;
    if (w_cnt !== 4'd1) begin
      errors++; $display("FAIL wire_inc got %0d exp 1", w_cnt);
    end
    w_rss.valid = 1;
    w_rss.pd = 34'h2_0000_0055;
    #1;
    checks++;
    if (w_rsd.valid !== 1'b1 || w_rsd.pd !== 34'h2_0000_0055) begin
      errors++;
      $display("FAIL wire_resp got %b/%0h exp 1/200000055", w_rsd.valid, w_rsd.pd);
    end
    @(negedge clk);
    w_rss.valid = 0;
    checks++;
    if (w_cnt !== 4'd0 || w_err !== 1'b0) begin
      errors++; $display("FAIL wire_dec got %0d/%b exp 0/0", w_cnt, w_err);
    end
  endtask

  initial begin
    test_reset();
    test_stream(1'b0);
    test_stream(1'b1);
    test_nposted();
    test_resp_hold();
    test_saturate();
    test_reset_mid();
    test_wire();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
